timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 13 +
 rtl/timer_presc.sv | 28 ++
 rtl/timer_ctrl.sv | 130 +++++++++++++
 tb/tb_timer_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl shared definitions: FSM state encoding and run-mode constants.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic ONESHOT  = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/timer_presc.sv
// timer_presc: down-counting prescaler, tick whenever the counter sits at zero.
module timer_presc
    import timer_ctrl_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               load,
    input  logic [PRESC_W-1:0] value,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load || cnt_q == '0) begin
            cnt_q <= value;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot/periodic down-counting timer with sticky irq.
// Optional prescaler enabled by defining TIMER_CTRL_PRESC_EN.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period,
    input  logic               irq_clr,
    output logic               busy,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               irq
);

    state_t             state_q;
    state_t             state_d;
    logic               mode_q;
    logic [WIDTH-1:0]   period_q;
    logic [WIDTH-1:0]   count_q;
    logic               tc_q;
    logic               irq_q;
    logic               tick;
    logic               accept;
    logic               term;

`ifdef TIMER_CTRL_PRESC_EN
    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            presc_q <= '0;
        end else if (accept) begin
            presc_q <= presc;
        end
    end

    timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk_in (clk_in),
        .rst    (rst),
        .load   (state_q == LOAD),
        .value  (presc_q),
        .tick   (tick)
    );
`else
    logic presc_unused;

    assign presc_unused = ^presc;
    assign tick         = 1'b1;
`endif

    assign accept = (state_q == IDLE) && start && !stop;
    assign term   = (state_q == RUN) && !stop && tick
                    && (count_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (term && mode_q == ONESHOT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter only moves on non-aborted LOAD/RUN cycles; zero is
    // resolved by reload or by holding, never by wrapping.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q   <= ONESHOT;
            period_q <= '0;
            count_q  <= '0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            tc_q <= term;
            if (term) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
            if (accept) begin
                mode_q   <= mode;
                period_q <= period;
            end
            if (state_q == LOAD && !stop) begin
                count_q <= period_q;
            end else if (state_q == RUN && !stop && tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - 1'b1;
                end else if (mode_q == PERIODIC) begin
                    count_q <= period_q;
                end
            end
        end
    end

    assign busy  = (state_q == LOAD) || (state_q == RUN);
    assign count = count_q;
    assign tc    = tc_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl against an arithmetic timing model.
module tb_timer_ctrl;

    localparam int W  = 16;
    localparam int PW = 8;
`ifdef TIMER_CTRL_PRESC_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  period = '0;
    logic          irq_clr = 1'b0;
    logic          busy;
    logic [W-1:0]  count;
    logic          tc;
    logic          irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_in = ~clk_in;

    timer_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .presc   (presc),
        .period  (period),
        .irq_clr (irq_clr),
        .busy    (busy),
        .count   (count),
        .tc      (tc),
        .irq     (irq)
    );

    // d = edges after the accepting edge (d >= 1). Ticks fall every
    // N+1 edges starting N+1 edges after the load edge; the (P+1)th
    // tick of each round is terminal.
    function automatic void model(input int d, input int p, input int n,
                                  input bit md, output int c,
                                  output bit b, output bit t);
        int e, m;
        bit is_tick;
        e       = d - 1;
        m       = e / (n + 1);
        is_tick = (e > 0) && (e % (n + 1) == 0);
        if (md) begin
            c = p - (m % (p + 1));
            b = 1'b1;
            t = is_tick && (m % (p + 1) == 0);
        end else if (m >= p + 1) begin
            c = 0;
            b = 1'b0;
            t = is_tick && (m == p + 1);
        end else begin
            c = p - m;
            b = 1'b1;
            t = 1'b0;
        end
    endfunction

    function automatic int eff_n(input int n);
        return PEN ? n : 0;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic launch(input int p, input int n, input bit md);
        period = W'(p);
        presc  = PW'(n);
        mode   = md;
        start  = 1'b1;
        stop   = 1'b0;
        step();
        start  = 1'b0;
    endtask

    task automatic go_idle();
        start   = 1'b0;
        stop    = 1'b1;
        irq_clr = 1'b1;
        step();
        stop    = 1'b0;
        irq_clr = 1'b0;
    endtask

    task automatic run_check(input string nm, input int p, input int n,
                             input bit md, input int len);
        int c;
        bit b, t;
        for (int d = 1; d <= len; d++) begin
            step();
            model(d, p, eff_n(n), md, c, b, t);
            total_cnt++;
            if (count !== W'(c) || busy !== b || tc !== t)
                $display("FAIL %s d=%0d got cnt=%0d busy=%b tc=%b exp cnt=%0d busy=%b tc=%b",
                         nm, d, count, busy, tc, c, b, t);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || count !== '0 || tc !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_init got busy=%b cnt=%0d tc=%b irq=%b exp 0 0 0 0",
                     busy, count, tc, irq);
        else pass_cnt++;
        launch(10, 0, 1'b0);
        run_check("reset_pre", 10, 0, 1'b0, 6);
        total_cnt++;
        if (count !== W'(5))
            $display("FAIL reset_run5 got cnt=%0d exp 5", count);
        else pass_cnt++;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || count !== '0 || tc !== 1'b0 || irq !== 1'b0)
            $display("FAIL reset_mid got busy=%b cnt=%0d tc=%b irq=%b exp 0 0 0 0",
                     busy, count, tc, irq);
        else pass_cnt++;
    endtask

    task automatic test_oneshot();
        launch(3, 0, 1'b0);
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL oneshot_load got busy=%b exp 1", busy);
        else pass_cnt++;
        run_check("oneshot", 3, 0, 1'b0, 8);
        total_cnt++;
        if (irq !== 1'b1)
            $display("FAIL oneshot_irq got %b exp 1", irq);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_periodic();
        launch(1, 2, 1'b1);
        run_check("periodic", 1, 2, 1'b1, 26);
        go_idle();
    endtask

    task automatic test_abort();
        int c, held;
        bit b, t;
        launch(20, 1, 1'b0);
        run_check("abort_pre", 20, 1, 1'b0, 3);
        model(3, 20, eff_n(1), 1'b0, c, b, t);
        held = c;
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (busy !== 1'b0 || count !== W'(held) || tc !== 1'b0)
                $display("FAIL abort_hold i=%0d got busy=%b cnt=%0d tc=%b exp 0 %0d 0",
                         i, busy, count, tc, held);
            else pass_cnt++;
            step();
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        total_cnt++;
        if (busy !== 1'b0 || count !== W'(held))
            $display("FAIL start_stop got busy=%b cnt=%0d exp 0 %0d",
                     busy, count, held);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_irq_race();
        launch(1, 0, 1'b0);
        step();
        step();
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL irq_before got %b exp 0", irq);
        else pass_cnt++;
        irq_clr = 1'b1;
        step();
        total_cnt++;
        if (irq !== 1'b1 || tc !== 1'b1)
            $display("FAIL irq_race got irq=%b tc=%b exp 1 1", irq, tc);
        else pass_cnt++;
        step();
        irq_clr = 1'b0;
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL irq_clear got %b exp 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_no_presc();
        int te;
        te = 1 + 3 * (eff_n(7) + 1);
        launch(2, 7, 1'b0);
        for (int d = 1; d <= te + 1; d++) begin
            step();
            if (d >= te - 1) begin
                total_cnt++;
                if (tc !== (d == te))
                    $display("FAIL presc7_tc d=%0d got %b exp %b", d, tc, d == te);
                else pass_cnt++;
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        int p, n, len, c;
        bit md, b, t, prev_b;
        for (int r = 0; r < 10; r++) begin
            p  = $urandom_range(0, 6);
            n  = $urandom_range(0, 3);
            md = 1'($urandom_range(0, 1));
            len = md ? 30 : (p + 1) * (eff_n(n) + 1) + 4;
            launch(p, n, md);
            prev_b = 1'b1;
            for (int d = 1; d <= len; d++) begin
                start  = prev_b ? 1'($urandom_range(0, 1)) : 1'b0;
                period = W'($urandom);
                presc  = PW'($urandom);
                mode   = 1'($urandom);
                step();
                model(d, p, eff_n(n), md, c, b, t);
                prev_b = b;
                total_cnt++;
                if (count !== W'(c) || busy !== b || tc !== t)
                    $display("FAIL random r=%0d d=%0d P=%0d N=%0d md=%b got cnt=%0d busy=%b tc=%b exp cnt=%0d busy=%b tc=%b",
                             r, d, p, n, md, count, busy, tc, c, b, t);
                else pass_cnt++;
            end
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_abort();
        test_irq_race();
        test_no_presc();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
